// File: rtl/riscv_run_pkg.sv
// riscv_run_pkg: shared state encoding for the run/reset sequencer
package riscv_run_pkg;
  typedef enum logic [1:0] {IDLE, RST, RUN, DONE} run_state_t;
endpackage

// File: rtl/riscv_cycle_counter.sv
// riscv_cycle_counter: clearable up-counter with terminal compare against a supplied last value
module riscv_cycle_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] last,
  output logic [CNT_W-1:0] cnt,
  output logic             term
);
  assign term = cnt == last;
  // clear wins over count so a phase boundary always restarts from zero
  always_ff @(posedge clk)
    if (rst || clr) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
endmodule

// File: rtl/riscv_run_ctrl.sv
// riscv_run_ctrl: sequences NUM_RUNS core runs, each a reset hold followed by a bounded enable window
module riscv_run_ctrl import riscv_run_pkg::*; #(
  parameter int CNT_W      = 16,
  parameter int RST_CYCLES = 1,
  parameter int NUM_RUNS   = 2,
  parameter int IDX_W      = $clog2(NUM_RUNS) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] run_len,
  input  logic             halt_req,
  output logic             core_reset,
  output logic             core_en,
  output logic             busy,
  output logic             done,
  output logic             halted_early,
  output logic [IDX_W-1:0] run_idx,
  output logic [CNT_W-1:0] cycle_cnt
);
  run_state_t state;
  logic [CNT_W-1:0] len, last, cnt;
  logic term, go, hold_end, run_end, last_run;
  assign go       = (state == IDLE || state == DONE) && start;
  assign last     = state == RUN ? len - 1'b1 : CNT_W'(RST_CYCLES - 1);
  assign hold_end = state == RST && term;
  assign run_end  = state == RUN && (term || halt_req);
  assign last_run = run_idx == IDX_W'(NUM_RUNS - 1);
  riscv_cycle_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk  (clk),
    .rst  (reset),
    .clr  (go || hold_end || run_end),
    .en   (state == RST || state == RUN),
    .last (last),
    .cnt  (cnt),
    .term (term)
  );
  // session FSM; every output is a register updated alongside the state
  always_ff @(posedge clk)
    if (reset) begin
      state        <= IDLE;
      len          <= '0;
      core_reset   <= 1'b1;
      core_en      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      halted_early <= 1'b0;
      run_idx      <= '0;
      cycle_cnt    <= '0;
    end else if (go) begin
      state        <= RST;
      len          <= run_len;
      core_reset   <= 1'b1;
      core_en      <= 1'b0;
      busy         <= 1'b1;
      done         <= 1'b0;
      halted_early <= 1'b0;
      run_idx      <= '0;
      cycle_cnt    <= '0;
    end else if (hold_end && len != '0) begin
      state      <= RUN;
      core_reset <= 1'b0;
      core_en    <= 1'b1;
    end else if (hold_end || run_end) begin
      core_reset <= 1'b1;
      core_en    <= 1'b0;
      if (run_end) halted_early <= halted_early | (halt_req & ~term);
      if (last_run) begin
        state <= DONE;
        busy  <= 1'b0;
        done  <= 1'b1;
        if (run_end) cycle_cnt <= cycle_cnt + 1'b1;
      end else begin
        state     <= RST;
        run_idx   <= run_idx + 1'b1;
        cycle_cnt <= '0;
      end
    end else if (state == RUN) cycle_cnt <= cycle_cnt + 1'b1;
endmodule
